// File: rtl/param_serializer.sv
// Parameterised N-to-1 serializer with selectable bit order, hold/pause and
// back-to-back frame reload; the captured word is kept on word_out for display.
module param_serializer #(
    parameter int unsigned WIDTH      = 16,
    parameter logic        IDLE_LEVEL = 1'b0,
    localparam int unsigned CNT_W     = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             lsb_first,
    input  logic             hold,
    input  logic [WIDTH-1:0] data_in,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_count,
    output logic [WIDTH-1:0] word_out,
    output logic [1:0]       state
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SHIFT  = 2'b01,
        ST_DONE   = 2'b10,
        ST_UNUSED = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   word_q,  word_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               lsb_q,   lsb_d;

    logic               load_c;
    logic               advance_c;
    logic               last_c;

    // A new frame may only be captured from IDLE or from the DONE gap cycle.
    assign load_c    = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    assign advance_c = (state_q == ST_SHIFT) & ~hold;
    assign last_c    = (cnt_q == LAST_BIT);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!hold && last_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = start ? ST_SHIFT : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
            lsb_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            lsb_q   <= lsb_d;
        end
    end

    // Datapath next values: capture, shift toward the active end with zero fill
    always_comb begin
        shreg_d = shreg_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        lsb_d   = lsb_q;
        if (load_c) begin
            shreg_d = data_in;
            word_d  = data_in;
            lsb_d   = lsb_first;
            cnt_d   = '0;
        end else if (advance_c) begin
            if (lsb_q) begin
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end else begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
        end else if (state_q != ST_SHIFT) begin
            cnt_d = '0;
        end
    end

    // Outputs: state-derived, except valid/serial which also follow hold
    always_comb begin
        serial_valid = 1'b0;
        serial_out   = IDLE_LEVEL;
        busy         = 1'b0;
        done         = 1'b0;
        bit_count    = cnt_q;
        word_out     = word_q;
        state        = state_q;
        case (state_q)
            ST_SHIFT: begin
                busy         = 1'b1;
                serial_valid = ~hold;
                if (!hold) begin
                    serial_out = lsb_q ? shreg_q[0] : shreg_q[WIDTH-1];
                end
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
